// File: rtl/reseed_task_gen_if.sv
// Stream bundle between the reseed filter, the task generator and the
// SMEM re-search engine: candidate input, end-of-read token input and
// task output, each with its AXI-Stream handshake.
interface reseed_task_gen_if #(
   parameter int unsigned POS_W = 8,
   parameter int unsigned KLS_W = 40
);
   logic             s_rs_tvalid;
   logic             s_rs_tready;
   logic [POS_W-1:0] s_rs_i;
   logic [POS_W-1:0] s_rs_j;
   logic [KLS_W-1:0] s_rs_s;
   logic             s_eor_tvalid;
   logic             s_eor_tready;
   logic             m_task_tvalid;
   logic             m_task_tready;
   logic [POS_W-1:0] m_task_pos;
   logic [KLS_W-1:0] m_task_min_intv;
   logic             m_task_tlast;
   logic             m_task_empty;

   // Task generator side.
   modport slave (
      input  s_rs_tvalid, s_rs_i, s_rs_j, s_rs_s, s_eor_tvalid, m_task_tready,
      output s_rs_tready, s_eor_tready, m_task_tvalid, m_task_pos,
             m_task_min_intv, m_task_tlast, m_task_empty
   );

   // Environment side: drives candidates and eor tokens, consumes tasks.
   modport master (
      output s_rs_tvalid, s_rs_i, s_rs_j, s_rs_s, s_eor_tvalid, m_task_tready,
      input  s_rs_tready, s_eor_tready, m_task_tvalid, m_task_pos,
             m_task_min_intv, m_task_tlast, m_task_empty
   );
endinterface

// File: rtl/reseed_task_gen.sv
// Reseed task generator: turns reseed candidates (i, j, s) into restart
// tasks (midpoint position, s+1 minimum interval), buffers them in a FIFO
// and marks the last task of each read with tlast. A read with no
// candidates produces a single empty token.
module reseed_task_gen #(
   parameter int unsigned POS_W = 8,
   parameter int unsigned KLS_W = 40,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   reseed_task_gen_if.slave    bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = POS_W + KLS_W;

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pending;
   logic [EW-1:0]    mem [DEPTH];
   logic [EW-1:0]    head;

   logic [POS_W:0]   pos_sum;
   logic [POS_W-1:0] new_pos;
   logic [KLS_W-1:0] new_min;

   logic rs_ready, eor_ready, out_valid, out_last, out_empty;
   logic push, pop, eor_acc;

   // Task arithmetic: rounded-up midpoint of [i, j] and saturating s+1.
   always_comb begin
      pos_sum = {1'b0, bus.s_rs_i} + {1'b0, bus.s_rs_j} + (POS_W+1)'(1);
      new_pos = pos_sum[POS_W:1];
      new_min = (&bus.s_rs_s) ? bus.s_rs_s : bus.s_rs_s + KLS_W'(1);
   end

   // Handshake and flag decode from the registered state and occupancy.
   // In COLLECT the newest entry is held back since it may turn out to be
   // the last of the read; the empty token takes priority in DRAIN.
   always_comb begin
      rs_ready  = 1'b0;
      eor_ready = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_empty = 1'b0;
      if (!rst) begin
         if (state == COLLECT) begin
            rs_ready  = (count < CNT_W'(DEPTH));
            eor_ready = ~bus.s_rs_tvalid;
            out_valid = (count >= CNT_W'(2));
         end else if (pending) begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_empty = 1'b1;
         end else begin
            out_valid = (count != '0);
            out_last  = (count == CNT_W'(1));
         end
      end
   end

   assign push    = bus.s_rs_tvalid & rs_ready;
   assign pop     = out_valid & bus.m_task_tready & ~out_empty;
   assign eor_acc = bus.s_eor_tvalid & eor_ready;
   assign head    = mem[rd_ptr];

   // Output port drive; data is zeroed whenever no real task is presented.
   always_comb begin
      bus.s_rs_tready     = rs_ready;
      bus.s_eor_tready    = eor_ready;
      bus.m_task_tvalid   = out_valid;
      bus.m_task_tlast    = out_last;
      bus.m_task_empty    = out_empty;
      bus.m_task_pos      = '0;
      bus.m_task_min_intv = '0;
      if (out_valid && !out_empty) begin
         bus.m_task_pos      = head[EW-1:KLS_W];
         bus.m_task_min_intv = head[KLS_W-1:0];
      end
   end

   // Task storage write port, kept reset-free so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= {new_pos, new_min};
      end
   end

   // FSM, FIFO pointers/occupancy and empty-token flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= COLLECT;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         pending <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         case (state)
            COLLECT: begin
               if (eor_acc) begin
                  state <= DRAIN;
                  if (count == '0) pending <= 1'b1;
               end
            end
            DRAIN: begin
               if (out_valid && bus.m_task_tready && out_last) begin
                  pending <= 1'b0;
                  state   <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_reseed_task_gen.sv
// Bench for reseed_task_gen: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and an independent monitor.
module tb_reseed_task_gen;
   localparam int unsigned POS_W = 8;
   localparam int unsigned KLS_W = 40;
   localparam int unsigned DEPTH = 16;
   localparam longint unsigned MAX_S = (64'd1 << KLS_W) - 64'd1;

   typedef struct packed {
      logic [POS_W-1:0] pos;
      logic [KLS_W-1:0] mi;
      logic             last;
      logic             empty;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reseed_task_gen_if #(.POS_W(POS_W), .KLS_W(KLS_W)) bus ();

   reseed_task_gen #(.POS_W(POS_W), .KLS_W(KLS_W), .DEPTH(DEPTH), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t exp_q[$];   // tasks of finished reads, in order
   beat_t read_q[$];  // tasks of the read still open
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_beats  = 0;
   logic  acc_rs   = 1'b0;
   logic  acc_eor  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic beat_t make_task(input int unsigned i, input int unsigned j,
                                       input longint unsigned s);
      beat_t b;
      b.pos   = POS_W'((i + j + 1) / 2);
      b.mi    = KLS_W'((s + 1 > MAX_S) ? MAX_S : s + 1);
      b.last  = 1'b0;
      b.empty = 1'b0;
      return b;
   endfunction

   // One clock: inputs were set at the preceding negedge; record what the
   // coming posedge will accept, update the model, land on the next negedge.
   task automatic step();
      #1;
      acc_rs  = bus.s_rs_tvalid && bus.s_rs_tready;
      acc_eor = bus.s_eor_tvalid && bus.s_eor_tready;
      if (rst) begin
         read_q.delete();
         exp_q.delete();
      end else begin
         if (acc_rs)
            read_q.push_back(make_task(32'(bus.s_rs_i), 32'(bus.s_rs_j), 64'(bus.s_rs_s)));
         if (acc_eor) begin
            if (read_q.size() == 0) begin
               beat_t e;
               e = '0;
               e.last = 1'b1;
               e.empty = 1'b1;
               exp_q.push_back(e);
            end else begin
               read_q[read_q.size()-1].last = 1'b1;
               while (read_q.size() > 0) exp_q.push_back(read_q.pop_front());
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      bus.s_rs_tvalid  = 1'b0;
      bus.s_eor_tvalid = 1'b0;
      bus.s_rs_i = '0;
      bus.s_rs_j = '0;
      bus.s_rs_s = '0;
   endtask

   task automatic cand(input int unsigned i, input int unsigned j, input longint unsigned s);
      bus.s_rs_tvalid = 1'b1;
      bus.s_rs_i = POS_W'(i);
      bus.s_rs_j = POS_W'(j);
      bus.s_rs_s = KLS_W'(s);
   endtask

   task automatic send_eor(input string name);
      int c;
      c = 0;
      bus.s_rs_tvalid  = 1'b0;
      bus.s_eor_tvalid = 1'b1;
      bus.m_task_tready = 1'b1;
      do begin
         step();
         c++;
      end while (!acc_eor && c < 60);
      bus.s_eor_tvalid = 1'b0;
      if (!acc_eor) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: eor not accepted within %0d cycles", name, c);
      end
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      idle();
      bus.m_task_tready = 1'b1;
      while ((exp_q.size() != 0 || bus.m_task_tvalid) && c < 300) begin
         step();
         c++;
      end
      if (c >= 300) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: output not drained, %0d tasks outstanding", name, exp_q.size());
      end
   endtask

   // Monitor: compares every completed output beat with the model and
   // checks that a stalled beat holds still.
   beat_t act, e, prev_beat;
   logic  prev_stall = 1'b0;
   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         prev_stall = 1'b0;
      end else if (bus.m_task_tvalid) begin
         act.pos   = bus.m_task_pos;
         act.mi    = bus.m_task_min_intv;
         act.last  = bus.m_task_tlast;
         act.empty = bus.m_task_empty;
         if (prev_stall) check("stall_stable", 64'(act), 64'(prev_beat));
         if (bus.m_task_tready) begin
            prev_stall = 1'b0;
            n_beats++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("beat", 64'(act), 64'(e));
            end else if (read_q.size() >= 2) begin
               e = read_q.pop_front();
               check("beat_open_read", 64'(act), 64'(e));
            end else begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h expected no beat", act);
            end
         end else begin
            prev_stall = 1'b1;
            prev_beat  = act;
         end
      end else begin
         if (prev_stall) check("valid_dropped", 64'(bus.m_task_tvalid), 64'd1);
         prev_stall = 1'b0;
      end
   end

   int unsigned ti[20];
   int unsigned tj[20];
   longint unsigned ts[20];
   int k, b0;
   longint unsigned rs;

   initial begin
      rst = 1'b1;
      idle();
      bus.m_task_tready = 1'b0;
      @(negedge clk);
      step();
      step();
      check("rst_rs_tready", 64'(bus.s_rs_tready), 64'd0);
      check("rst_eor_tready", 64'(bus.s_eor_tready), 64'd0);
      check("rst_tvalid", 64'(bus.m_task_tvalid), 64'd0);
      check("rst_data", 64'({bus.m_task_pos, bus.m_task_min_intv}), 64'd0);
      rst = 1'b0;
      step();
      check("idle_rs_tready", 64'(bus.s_rs_tready), 64'd1);
      check("idle_eor_tready", 64'(bus.s_eor_tready), 64'd1);
      check("idle_tvalid", 64'(bus.m_task_tvalid), 64'd0);

      // Single candidate read.
      bus.m_task_tready = 1'b1;
      b0 = n_beats;
      cand(10, 41, 3);
      step();
      check("t1_held_back", 64'(bus.m_task_tvalid), 64'd0);
      idle();
      bus.s_eor_tvalid = 1'b1;
      step();
      bus.s_eor_tvalid = 1'b0;
      check("t1_valid", 64'(bus.m_task_tvalid), 64'd1);
      check("t1_pos", 64'(bus.m_task_pos), 64'd26);
      check("t1_min_intv", 64'(bus.m_task_min_intv), 64'd4);
      check("t1_flags", 64'({bus.m_task_tlast, bus.m_task_empty}), 64'b10);
      step();
      step();
      check("t1_beat_count", 64'(n_beats - b0), 64'd1);
      check("t1_back_collect", 64'(bus.s_eor_tready), 64'd1);

      // Read with no candidates.
      bus.m_task_tready = 1'b0;
      bus.s_eor_tvalid = 1'b1;
      step();
      bus.s_eor_tvalid = 1'b0;
      check("t2_valid", 64'(bus.m_task_tvalid), 64'd1);
      check("t2_flags", 64'({bus.m_task_tlast, bus.m_task_empty}), 64'b11);
      check("t2_data", 64'({bus.m_task_pos, bus.m_task_min_intv}), 64'd0);
      check("t2_eor_blocked", 64'(bus.s_eor_tready), 64'd0);
      step();
      check("t2_eor_blocked2", 64'(bus.s_eor_tready), 64'd0);
      bus.m_task_tready = 1'b1;
      step();
      check("t2_eor_ready_again", 64'(bus.s_eor_tready), 64'd1);
      check("t2_done", 64'(bus.m_task_tvalid), 64'd0);

      // Three back-to-back candidates, eor three cycles later.
      cand(1, 2, 5);
      step();
      check("t3_after_c1", 64'(bus.m_task_tvalid), 64'd0);
      cand(3, 4, 6);
      step();
      check("t3_beat1_valid", 64'(bus.m_task_tvalid), 64'd1);
      check("t3_beat1_pos", 64'(bus.m_task_pos), 64'd2);
      cand(5, 6, 7);
      step();
      check("t3_beat2_valid", 64'(bus.m_task_tvalid), 64'd1);
      check("t3_beat2_pos", 64'(bus.m_task_pos), 64'd4);
      idle();
      step();
      check("t3_hold_back", 64'(bus.m_task_tvalid), 64'd0);
      step();
      step();
      bus.s_eor_tvalid = 1'b1;
      step();
      bus.s_eor_tvalid = 1'b0;
      check("t3_beat3_valid", 64'(bus.m_task_tvalid), 64'd1);
      check("t3_beat3_last", 64'(bus.m_task_tlast), 64'd1);
      check("t3_beat3_pos", 64'(bus.m_task_pos), 64'd6);
      step();

      // FIFO fill with output stalled.
      for (int n = 0; n < 20; n++) begin
         ti[n] = $urandom_range(0, 255);
         tj[n] = $urandom_range(0, 255);
         ts[n] = longint'($urandom_range(0, 1000000));
      end
      b0 = n_beats;
      bus.m_task_tready = 1'b0;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         if (k < 20) cand(ti[k], tj[k], ts[k]);
         step();
         if (acc_rs) k++;
      end
      check("t4_accepted", 64'(k), 64'd16);
      check("t4_full_rs_tready", 64'(bus.s_rs_tready), 64'd0);
      bus.m_task_tready = 1'b1;
      for (int c = 0; c < 100 && k < 20; c++) begin
         cand(ti[k], tj[k], ts[k]);
         step();
         if (acc_rs) k++;
      end
      check("t4_all_accepted", 64'(k), 64'd20);
      send_eor("t4_eor");
      drain("t4_drain");
      check("t4_beat_count", 64'(n_beats - b0), 64'd20);

      // Arithmetic boundaries in one read.
      bus.m_task_tready = 1'b1;
      cand(0, 255, MAX_S);
      step();
      cand(255, 255, 64'd17);
      step();
      check("t5_first_pos", 64'(bus.m_task_pos), 64'd128);
      check("t5_first_min_sat", 64'(bus.m_task_min_intv), 64'(MAX_S));
      send_eor("t5_eor");
      check("t5_last_pos", 64'(bus.m_task_pos), 64'd255);
      check("t5_last_min", 64'(bus.m_task_min_intv), 64'd18);
      drain("t5_drain");

      // Simultaneous candidate and eor, then reset while draining.
      bus.m_task_tready = 1'b0;
      cand(100, 50, 9);
      bus.s_eor_tvalid = 1'b1;
      step();
      check("t6_cand_first", 64'({acc_rs, acc_eor}), 64'b10);
      bus.s_rs_tvalid = 1'b0;
      step();
      check("t6_eor_next", 64'(acc_eor), 64'd1);
      bus.s_eor_tvalid = 1'b0;
      check("t6_last_beat", 64'({bus.m_task_tvalid, bus.m_task_tlast}), 64'b11);
      check("t6_pos", 64'(bus.m_task_pos), 64'd75);
      rst = 1'b1;
      step();
      check("t6_rst_valids", 64'({bus.m_task_tvalid, bus.s_rs_tready, bus.s_eor_tready}), 64'd0);
      rst = 1'b0;
      step();
      check("t6_post_rst", 64'({bus.m_task_tvalid, bus.s_rs_tready, bus.s_eor_tready}), 64'b011);
      b0 = n_beats;
      bus.m_task_tready = 1'b1;
      cand(7, 9, 1);
      step();
      send_eor("t6_eor");
      drain("t6_drain");
      check("t6_only_new_beat", 64'(n_beats - b0), 64'd1);

      // Randomized traffic with AXI-compliant holding of unaccepted beats.
      for (int c = 0; c < 600; c++) begin
         if (!(bus.s_rs_tvalid && !acc_rs)) begin
            rs = {32'($urandom), 32'($urandom)} & MAX_S;
            if ($urandom_range(0, 7) == 0) rs = MAX_S;
            cand($urandom_range(0, 255), ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 255), rs);
            bus.s_rs_tvalid = ($urandom_range(0, 2) != 0);
         end
         if (!(bus.s_eor_tvalid && !acc_eor))
            bus.s_eor_tvalid = ($urandom_range(0, 9) == 0);
         bus.m_task_tready = ($urandom_range(0, 3) != 0);
         step();
      end
      send_eor("rand_eor");
      drain("rand_drain");
      check("final_model_empty", 64'(exp_q.size() + read_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
